spi_shift_engine: RTL and testbench
===================================

# spi_shift_engine

Parametrised, frame-controlled serial/parallel shift engine for the SPI datapath. It is the successor to the fixed-width universal shift register. It adds parallel load, runtime MSB/LSB-first order, variable frame length, a bit counter, and a busy/done handshake. A word is transmitted on `o_ser_data` while a word is received on `i_ser_data`, both full-duplex. The SPI master/slave control FSM drives it with one shift strobe per SCK bit.

## Interface
- `WIDTH`, 8, maximum frame length in bits (≥2)
- `CW`, $clog2(WIDTH+1), width of frame-length input; derived, do not override
- `i_clk`  input  1  system clock; all state updates on rising edge
- `i_rst`  input  1  asynchronous, active-low reset
- `i_load`  input  1  start-of-frame pulse; accepted only in IDLE
- `i_par_data`  input  WIDTH  transmit word, sampled on accepted load
- `i_frame_len`  input  CW  frame length, sampled on load; 0 or >WIDTH means WIDTH
- `i_lsb_first`  input  1  bit order, sampled on load; 1 = LSB first
- `i_shift_en`  input  1  one-cycle bit strobe; samples `i_ser_data` and advances
- `i_ser_data`  input  1  serial receive bit
- `i_clear`  input  1  synchronous frame abort
- `o_ser_data`  output  1  current transmit bit
- `o_par_data`  output  WIDTH  shift register contents; received word valid when `o_done` is high
- `o_busy`  output  1  frame in progress
- `o_done`  output  1  one-cycle end-of-frame pulse

## Operation
- States:
  - IDLE: `o_busy`=0. Transitions to SHIFT on `i_load`.
  - SHIFT: `o_busy`=1. Returns to IDLE after the last strobe or on `i_clear`.
- Load: `len` = effective frame length. Register ← `i_par_data` with bits ≥ `len` forced to 0. Bit counter ← `len`. Order flag latched.
- MSB-first strobe: register shifts left within `[len-1:0]`. `i_ser_data` enters bit 0. Bits ≥ `len` stay 0. Transmit bit = `reg[len-1]`.
- LSB-first strobe: register shifts right. `i_ser_data` enters bit `len-1`. Transmit bit = `reg[0]`.
- Each strobe in SHIFT decrements the counter. The strobe that takes the counter 1→0 ends the frame. The received word is right-aligned in `o_par_data[len-1:0]` with upper bits 0.
- `o_ser_data` is 0 in IDLE. In SHIFT it is the transmit bit per the rules above, driven from registered state with no combinational path from inputs.
- `i_load` while busy: ignored.
- `i_load` together with `i_shift_en` in IDLE: load wins; the strobe is ignored.
- `i_shift_en` in IDLE: ignored; register unchanged.
- `i_clear` in SHIFT: return to IDLE, no `o_done`, register contents retained.
- `i_clear` has priority over `i_shift_en` in the same cycle.
- `i_clear` in IDLE: no effect.
- Strobes may be gapped by any number of idle cycles; state holds between strobes.
- Reset (`i_rst`=0) acts immediately, including mid-frame:
  - state IDLE, register 0, counter 0
  - `o_ser_data`=0, `o_par_data`=0, `o_busy`=0, `o_done`=0

## Timing
- Load accepted at edge k: from k, `o_busy`=1 and `o_ser_data` = first bit. There is zero-latency first-bit presentation, so the first bit is valid before the first strobe (CPHA=0 compatible).
- Strobe at edge m: `i_ser_data` is sampled at m and `o_ser_data` shows the next bit after m.
- Last strobe at edge n: after n, `o_busy`=0, `o_done`=1 for exactly one cycle, `o_par_data` holds the final word, and `o_ser_data`=0.
- `o_par_data` holds its value until the next accepted load or reset.
- A new load is accepted in the cycle `o_done` is high. Back-to-back frames need no gap cycle.
- A frame of `len` bits takes `len` strobes. Latency from last strobe to `o_done` is 1 edge.

## Test plan
- **Reset:** assert `i_rst`=0 mid-simulation with `i_clk` stopped → all outputs 0 immediately. Release; toggle `i_shift_en` in IDLE → `o_par_data` stays 8'h00 and `o_busy` stays 0.
- **MSB-first full frame:** WIDTH=8, load 8'hC1, `i_frame_len`=0, `i_lsb_first`=0, drive 8'h3C MSB-first over 8 strobes.
  - `o_ser_data` = 1,1,0,0,0,0,0,1.
  - `o_done` pulses once after the 8th strobe; `o_par_data`=8'h3C.
- **LSB-first full frame:** load 8'hC1, `i_lsb_first`=1, drive 8'h81 LSB-first.
  - `o_ser_data` = 1,0,0,0,0,0,1,1.
  - `o_par_data`=8'h81 at `o_done`.
- **Short frame:** `i_frame_len`=5, MSB-first, load 8'hFF, receive 1,0,1,1,0.
  - `o_ser_data` = 1,1,1,1,1.
  - `o_done` after the 5th strobe; `o_par_data`=8'h16.
- **Gapped strobes / ignored inputs:** strobes spaced 0–4 cycles apart.
  - A second `i_load` with 8'hFF mid-frame is ignored; the frame completes with the original data.
  - Load back-to-back in the `o_done` cycle → new frame starts with no bubble.
- **Abort:** after 3 strobes, assert `i_clear` together with `i_shift_en` → `o_busy`=0 next edge, no `o_done`, register unchanged by that strobe. Repeat with `i_rst`=0 after 3 strobes → all outputs 0 asynchronously.

Source files
------------

// File: rtl/spi_shift_engine.sv
// Frame-controlled full-duplex shift engine for the SPI datapath.
// One shift strobe per SCK bit; the first transmit bit is presented as soon as the load is accepted.
module spi_shift_engine #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_par_data,
    input  logic [CW-1:0]    i_frame_len,
    input  logic             i_lsb_first,
    input  logic             i_shift_en,
    input  logic             i_ser_data,
    input  logic             i_clear,
    output logic             o_ser_data,
    output logic [WIDTH-1:0] o_par_data,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [CW-1:0]    len_q,   len_d;
    logic             lsb_q,   lsb_d;
    logic             done_q,  done_d;

    logic [CW-1:0]    eff_len;
    logic [CW-1:0]    len_m1;
    logic [WIDTH-1:0] mask_load;
    logic [WIDTH-1:0] mask_cur;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;
    logic [WIDTH-1:0] msb_sel;
    logic             accept_load;
    logic             do_strobe;

    assign eff_len     = ((i_frame_len == '0) || (i_frame_len > CW'(WIDTH))) ? CW'(WIDTH) : i_frame_len;
    assign len_m1      = len_q - CW'(1);
    assign accept_load = (state_q == S_IDLE) && i_load;
    // Abort outranks the strobe, so a strobe arriving with i_clear never touches the register.
    assign do_strobe   = (state_q == S_SHIFT) && !i_clear && i_shift_en;

    // Per-bit frame masks, shift candidates and the MSB-first transmit tap at bit len-1.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        localparam logic [CW-1:0] IDX = CW'(gi);

        assign mask_load[gi] = (IDX < eff_len);
        assign mask_cur[gi]  = (IDX < len_q);
        assign msb_sel[gi]   = shreg_q[gi] & (len_m1 == IDX);

        if (gi == 0) begin : g_lo
            assign shl_next[gi] = i_ser_data;
        end else begin : g_mid
            assign shl_next[gi] = shreg_q[gi-1] & mask_cur[gi];
        end

        if (gi == WIDTH - 1) begin : g_top
            assign shr_next[gi] = (len_m1 == IDX) ? i_ser_data : 1'b0;
        end else begin : g_low
            assign shr_next[gi] = (len_m1 == IDX) ? i_ser_data : shreg_q[gi+1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_load) state_d = S_SHIFT;
            S_SHIFT: begin
                if (i_clear)                               state_d = S_IDLE;
                else if (i_shift_en && cnt_q == CW'(1))    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (state_q == S_SHIFT);
        o_ser_data = 1'b0;
        if (state_q == S_SHIFT) begin
            o_ser_data = lsb_q ? shreg_q[0] : (|msb_sel);
        end
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        lsb_d   = lsb_q;
        done_d  = 1'b0;
        if (accept_load) begin
            shreg_d = i_par_data & mask_load;
            cnt_d   = eff_len;
            len_d   = eff_len;
            lsb_d   = i_lsb_first;
        end else if (do_strobe) begin
            shreg_d = lsb_q ? shr_next : shl_next;
            cnt_d   = cnt_q - CW'(1);
            done_d  = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            lsb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            lsb_q   <= lsb_d;
            done_q  <= done_d;
        end
    end

    assign o_par_data = shreg_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: frames in both bit orders, short frames, gaps, abort and reset.
module tb_spi_shift_engine;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             i_clk;
    logic             i_rst;
    logic             i_load;
    logic [WIDTH-1:0] i_par_data;
    logic [CW-1:0]    i_frame_len;
    logic             i_lsb_first;
    logic             i_shift_en;
    logic             i_ser_data;
    logic             i_clear;
    logic             o_ser_data;
    logic [WIDTH-1:0] o_par_data;
    logic             o_busy;
    logic             o_done;

    int  n_vec  = 0;
    int  n_err  = 0;
    bit  clk_run = 1'b1;

    spi_shift_engine #(.WIDTH(WIDTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (i_load),
        .i_par_data  (i_par_data),
        .i_frame_len (i_frame_len),
        .i_lsb_first (i_lsb_first),
        .i_shift_en  (i_shift_en),
        .i_ser_data  (i_ser_data),
        .i_clear     (i_clear),
        .o_ser_data  (o_ser_data),
        .o_par_data  (o_par_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // Gateable clock so reset can be exercised with no edges present.
    initial begin
        i_clk = 1'b0;
        forever begin
            #5;
            if (clk_run) i_clk = ~i_clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ser"},  32'(o_ser_data), 32'h0);
        check({tag, ".par"},  32'(o_par_data), 32'h0);
        check({tag, ".busy"}, 32'(o_busy),     32'h0);
        check({tag, ".done"}, 32'(o_done),     32'h0);
    endtask

    // Bits of rx/exp_tx are listed in wire order: index n-1 goes first.
    // Returns at the o_done cycle so the caller can load the next frame back to back.
    task automatic do_frame(input string tag, input logic [7:0] pd, input logic [CW-1:0] fl,
                            input logic lsb, input logic [7:0] rx, input int n,
                            input logic [7:0] exp_tx, input logic [7:0] exp_rx,
                            input int max_gap, input bit inject_load);
        i_load = 1'b1; i_par_data = pd; i_frame_len = fl; i_lsb_first = lsb;
        tick();
        i_load = 1'b0; i_par_data = 8'h00; i_frame_len = '0; i_lsb_first = 1'b0;
        check({tag, ".busy_after_load"}, 32'(o_busy), 32'h1);
        check({tag, ".no_done_after_load"}, 32'(o_done), 32'h0);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.tx%0d", tag, i), 32'(o_ser_data), 32'(exp_tx[n-1-i]));
            i_shift_en = 1'b1; i_ser_data = rx[n-1-i];
            if (inject_load && i == 3) begin
                i_load = 1'b1; i_par_data = 8'hFF;
            end
            tick();
            i_shift_en = 1'b0; i_ser_data = 1'b0; i_load = 1'b0; i_par_data = 8'h00;
            if (i < n - 1) begin
                check($sformatf("%s.busy%0d", tag, i), 32'(o_busy), 32'h1);
                check($sformatf("%s.nodone%0d", tag, i), 32'(o_done), 32'h0);
                for (int g = 0; g < (max_gap == 0 ? 0 : i % (max_gap + 1)); g++) tick();
            end
        end
        check({tag, ".done"},     32'(o_done),     32'h1);
        check({tag, ".idle"},     32'(o_busy),     32'h0);
        check({tag, ".ser_idle"}, 32'(o_ser_data), 32'h0);
        check({tag, ".rx_word"},  32'(o_par_data), 32'(exp_rx));
    endtask

    initial begin
        i_rst = 1'b0; i_load = 1'b0; i_par_data = '0; i_frame_len = '0; i_lsb_first = 1'b0;
        i_shift_en = 1'b0; i_ser_data = 1'b0; i_clear = 1'b0;
        #1;
        check_all_zero("reset_init");
        tick(); tick();
        check_all_zero("reset_hold");
        i_rst = 1'b1;
        tick();

        // Strobes in IDLE must not disturb the register.
        i_shift_en = 1'b1; i_ser_data = 1'b1;
        tick(); tick(); tick();
        i_shift_en = 1'b0; i_ser_data = 1'b0;
        check("idle_strobe.par",  32'(o_par_data), 32'h00);
        check("idle_strobe.busy", 32'(o_busy),     32'h0);

        do_frame("msb8", 8'hC1, 4'd0, 1'b0, 8'h3C, 8, 8'hC1, 8'h3C, 0, 1'b0);
        tick();
        check("msb8.done_once", 32'(o_done),     32'h0);
        check("msb8.par_hold",  32'(o_par_data), 32'h3C);

        do_frame("lsb8", 8'hC1, 4'd0, 1'b1, 8'h81, 8, 8'h83, 8'h81, 0, 1'b0);
        // Back-to-back loads from here on: each frame starts in the previous o_done cycle.
        do_frame("short5", 8'hFF, 4'd5, 1'b0, 8'h16, 5, 8'h1F, 8'h16, 0, 1'b0);
        do_frame("gapped", 8'hA5, 4'd0, 1'b0, 8'h5A, 8, 8'hA5, 8'h5A, 4, 1'b1);
        do_frame("len9_lsb", 8'h3C, 4'd9, 1'b1, 8'hF0, 8, 8'h3C, 8'h0F, 2, 1'b0);
        tick();
        check("len9_lsb.done_once", 32'(o_done), 32'h0);

        // Abort with a coincident strobe: the strobe must not land.
        i_load = 1'b1; i_par_data = 8'hC1; i_frame_len = 4'd0; i_lsb_first = 1'b0;
        tick();
        i_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_shift_en = 1'b1; i_ser_data = 1'b1;
            tick();
        end
        check("abort.par_pre", 32'(o_par_data), 32'h0F);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0; i_shift_en = 1'b0; i_ser_data = 1'b0;
        check("abort.busy", 32'(o_busy),     32'h0);
        check("abort.done", 32'(o_done),     32'h0);
        check("abort.par",  32'(o_par_data), 32'h0F);
        check("abort.ser",  32'(o_ser_data), 32'h0);
        tick();
        check("abort.no_done_later", 32'(o_done), 32'h0);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clear_idle.par",  32'(o_par_data), 32'h0F);
        check("clear_idle.busy", 32'(o_busy),     32'h0);

        // Mid-frame reset with the clock halted.
        i_load = 1'b1; i_par_data = 8'hC1;
        tick();
        i_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_shift_en = 1'b1; i_ser_data = 1'b1;
            tick();
        end
        i_shift_en = 1'b0; i_ser_data = 1'b0;
        check("rst_mid.busy_pre", 32'(o_busy), 32'h1);
        clk_run = 1'b0;
        #20;
        i_rst = 1'b0;
        #2;
        check_all_zero("rst_mid");
        #5;
        i_rst = 1'b1;
        clk_run = 1'b1;
        tick();
        check_all_zero("rst_release");

        do_frame("post_rst", 8'h96, 4'd3, 1'b1, 8'h05, 3, 8'h03, 8'h05, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
